control_cmd_serializer: RTL and testbench

Host-side command transmitter for the control unit's byte protocol. It accepts one whole command per request (opcode plus typed fields) and serialises it into the opcode-then-payload byte stream on out_byte/out_valid. Each byte is advanced on the receiver's single-cycle `next` acknowledge. It sits between the SPI/UART front end or test sequencer and control_unit, driving control_unit.in_byte/in_valid and consuming control_unit.next.

---
 rtl/control_cmd_serializer_pkg.sv | 54 +++++
 rtl/control_cmd_serializer.sv | 166 ++++++++++++++++
 tb/tb_control_cmd_serializer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_cmd_serializer_pkg.sv
// Shared opcode codes, serializer state encoding and payload-length decode for the control byte protocol.
// Used by the host-side serializer and usable by the receiving control unit.
package control_cmd_serializer_pkg;

    localparam logic [7:0] COMMAND_BEGIN_PROGRAM      = 8'h01;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h02;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_0  = 8'h03;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_1  = 8'h04;
    localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_0 = 8'h05;
    localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_1 = 8'h06;
    localparam logic [7:0] COMMAND_ALLOC_DELAY        = 8'h07;
    localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h08;
    localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h09;
    localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h0A;
    localparam logic [7:0] COMMAND_END_PROGRAM        = 8'h0B;

    localparam int CMD_PAYLOAD_MAX = 6;

    typedef enum logic [1:0] {
        CMD_SER_IDLE    = 2'd0,
        CMD_SER_OPCODE  = 2'd1,
        CMD_SER_PAYLOAD = 2'd2
    } cmd_ser_state_e;

    typedef struct packed {
        logic       vld;
        logic [2:0] len;
    } cmd_len_t;

    function automatic cmd_len_t cmd_payload_len(input logic [7:0] opcode,
                                                 input logic [1:0] block_bytes,
                                                 input logic [1:0] data_bytes);
        cmd_len_t r;
        r.vld = 1'b1;
        r.len = 3'd0;
        case (opcode)
            COMMAND_BEGIN_PROGRAM, COMMAND_COMMIT_REG_UPDATES, COMMAND_END_PROGRAM:
                r.len = 3'd0;
            COMMAND_WRITE_BLOCK_INSTR:
                r.len = 3'(block_bytes) + 3'd4;
            COMMAND_WRITE_BLOCK_REG_0, COMMAND_WRITE_BLOCK_REG_1,
            COMMAND_UPDATE_BLOCK_REG_0, COMMAND_UPDATE_BLOCK_REG_1:
                r.len = 3'(block_bytes) + 3'(data_bytes);
            COMMAND_ALLOC_DELAY:
                r.len = 3'd6;
            COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN:
                r.len = 3'(data_bytes);
            default:
                r.vld = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/control_cmd_serializer.sv
// Serialises one whole command into opcode-then-payload bytes; opcode valid the cycle after accept.
// Each byte holds until the receiver's `next` pulse; req_ready is low while a command is in flight.
module control_cmd_serializer
    import control_cmd_serializer_pkg::*;
#(
    parameter int N_BLOCKS           = 256,
    parameter int DATA_WIDTH         = 16,
    parameter int ACK_TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_block,
    input  logic [31:0] req_data,
    input  logic [23:0] req_delay_size,
    input  logic [23:0] req_init_delay,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        next,
    output logic        busy,
    output logic        done,
    output logic        cmd_error,
    output logic        ack_timeout,
    output logic [15:0] bytes_sent
);

    localparam int BLOCK_BYTES = (N_BLOCKS > 256) ? 2 : 1;
    localparam int DATA_BYTES  = (DATA_WIDTH == 24) ? 3 : 2;
    localparam int CW          = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT_CYCLES - 1);

    cmd_ser_state_e state_q;
    logic [47:0]    payload_q;
    logic [2:0]     rem_q;
    logic [7:0]     out_byte_q;
    logic           out_valid_q;
    logic           done_q;
    logic           cmd_error_q;
    logic           ack_timeout_q;
    logic [15:0]    bytes_sent_q;
    logic [CW-1:0]  ack_cnt_q;

    cmd_len_t    len_d;
    logic [47:0] payload_d;
    logic [47:0] blk_w;
    logic [47:0] dat_w;
    logic        ack_hit;
    logic        unused_blk;

    function automatic logic [7:0] pick_byte(input logic [47:0] p, input logic [2:0] idx);
        return 8'(p >> {idx, 3'b000});
    endfunction

    // Payload is right-aligned so the highest-indexed byte (block, then data MSB) goes out first.
    always_comb begin
        len_d     = cmd_payload_len(req_cmd, 2'(BLOCK_BYTES), 2'(DATA_BYTES));
        blk_w     = 48'(req_block[8*BLOCK_BYTES-1:0]);
        dat_w     = 48'(req_data[8*DATA_BYTES-1:0]);
        payload_d = '0;
        case (req_cmd)
            COMMAND_WRITE_BLOCK_INSTR:
                payload_d = (blk_w << 32) | 48'(req_data);
            COMMAND_WRITE_BLOCK_REG_0, COMMAND_WRITE_BLOCK_REG_1,
            COMMAND_UPDATE_BLOCK_REG_0, COMMAND_UPDATE_BLOCK_REG_1:
                payload_d = (blk_w << (8*DATA_BYTES)) | dat_w;
            COMMAND_ALLOC_DELAY:
                payload_d = {req_delay_size, req_init_delay};
            COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN:
                payload_d = dat_w;
            default:
                payload_d = '0;
        endcase
    end

    assign ack_hit    = out_valid_q && next;
    assign unused_blk = ^req_block;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= CMD_SER_IDLE;
            payload_q     <= '0;
            rem_q         <= '0;
            out_byte_q    <= '0;
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            cmd_error_q   <= 1'b0;
            ack_timeout_q <= 1'b0;
            bytes_sent_q  <= '0;
            ack_cnt_q     <= '0;
        end else begin
            done_q        <= 1'b0;
            cmd_error_q   <= 1'b0;
            ack_timeout_q <= 1'b0;
            if (ack_hit) begin
                bytes_sent_q <= bytes_sent_q + 16'd1;
            end
            if (ack_hit || !out_valid_q) begin
                ack_cnt_q <= '0;
            end else begin
                ack_cnt_q <= ack_cnt_q + CW'(1);
            end
            unique case (state_q)
                CMD_SER_IDLE: begin
                    if (req_valid) begin
                        if (!len_d.vld) begin
                            cmd_error_q <= 1'b1;
                        end else begin
                            payload_q   <= payload_d;
                            rem_q       <= len_d.len;
                            out_byte_q  <= req_cmd;
                            out_valid_q <= 1'b1;
                            state_q     <= CMD_SER_OPCODE;
                        end
                    end
                end
                CMD_SER_OPCODE: begin
                    if (next) begin
                        if (rem_q == 3'd0) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= CMD_SER_IDLE;
                        end else begin
                            out_byte_q <= pick_byte(payload_q, rem_q - 3'd1);
                            state_q    <= CMD_SER_PAYLOAD;
                        end
                    end else if (ack_cnt_q == ACK_LAST) begin
                        out_valid_q   <= 1'b0;
                        ack_timeout_q <= 1'b1;
                        ack_cnt_q     <= '0;
                        state_q       <= CMD_SER_IDLE;
                    end
                end
                CMD_SER_PAYLOAD: begin
                    if (next) begin
                        rem_q <= rem_q - 3'd1;
                        if (rem_q == 3'd1) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= CMD_SER_IDLE;
                        end else begin
                            out_byte_q <= pick_byte(payload_q, rem_q - 3'd2);
                        end
                    end else if (ack_cnt_q == ACK_LAST) begin
                        out_valid_q   <= 1'b0;
                        ack_timeout_q <= 1'b1;
                        ack_cnt_q     <= '0;
                        state_q       <= CMD_SER_IDLE;
                    end
                end
                default: state_q <= CMD_SER_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == CMD_SER_IDLE);
    assign busy        = ~req_ready;
    assign out_byte    = out_byte_q;
    assign out_valid   = out_valid_q;
    assign done        = done_q;
    assign cmd_error   = cmd_error_q;
    assign ack_timeout = ack_timeout_q;
    assign bytes_sent  = bytes_sent_q;

endmodule

// File: tb/tb_control_cmd_serializer.sv
// Bench for control_cmd_serializer: directed vector table, timeout/reset sequences, random commands vs byte-list model.
module tb_control_cmd_serializer;
    import control_cmd_serializer_pkg::*;

    localparam int ACK_TO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [15:0] req_block;
    logic [31:0] req_data;
    logic [23:0] req_delay_size;
    logic [23:0] req_init_delay;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        next;
    logic        busy;
    logic        done;
    logic        cmd_error;
    logic        ack_timeout;
    logic [15:0] bytes_sent;

    always #5 clk = ~clk;

    control_cmd_serializer #(
        .N_BLOCKS(256), .DATA_WIDTH(16), .ACK_TIMEOUT_CYCLES(ACK_TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_block(req_block), .req_data(req_data),
        .req_delay_size(req_delay_size), .req_init_delay(req_init_delay),
        .out_byte(out_byte), .out_valid(out_valid), .next(next),
        .busy(busy), .done(done), .cmd_error(cmd_error),
        .ack_timeout(ack_timeout), .bytes_sent(bytes_sent)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int  done_cnt, err_cnt, to_cnt, stall_cyc, acked;
    bit  ready_bad, stable_bad, lat_ov, finished;
    int  model_bs = 0;
    bit  model_err;

    logic [7:0] ops [11] = '{COMMAND_BEGIN_PROGRAM, COMMAND_WRITE_BLOCK_INSTR,
                             COMMAND_WRITE_BLOCK_REG_0, COMMAND_WRITE_BLOCK_REG_1,
                             COMMAND_UPDATE_BLOCK_REG_0, COMMAND_UPDATE_BLOCK_REG_1,
                             COMMAND_ALLOC_DELAY, COMMAND_SET_INPUT_GAIN,
                             COMMAND_SET_OUTPUT_GAIN, COMMAND_COMMIT_REG_UPDATES,
                             COMMAND_END_PROGRAM};

    // Expected wire bytes listed field by field (1 block byte, 2 data bytes at these parameters).
    task automatic ref_model(input logic [7:0] op, input logic [15:0] blk, input logic [31:0] dat,
                             input logic [23:0] ds, input logic [23:0] id);
        exp_q.delete();
        model_err = 1'b0;
        case (op)
            COMMAND_BEGIN_PROGRAM, COMMAND_COMMIT_REG_UPDATES, COMMAND_END_PROGRAM:
                exp_q.push_back(op);
            COMMAND_WRITE_BLOCK_INSTR: begin
                exp_q.push_back(op);
                exp_q.push_back(blk[7:0]);
                for (int i = 3; i >= 0; i--) exp_q.push_back(dat[8*i +: 8]);
            end
            COMMAND_WRITE_BLOCK_REG_0, COMMAND_WRITE_BLOCK_REG_1,
            COMMAND_UPDATE_BLOCK_REG_0, COMMAND_UPDATE_BLOCK_REG_1: begin
                exp_q.push_back(op);
                exp_q.push_back(blk[7:0]);
                exp_q.push_back(dat[15:8]);
                exp_q.push_back(dat[7:0]);
            end
            COMMAND_ALLOC_DELAY: begin
                exp_q.push_back(op);
                for (int i = 2; i >= 0; i--) exp_q.push_back(ds[8*i +: 8]);
                for (int i = 2; i >= 0; i--) exp_q.push_back(id[8*i +: 8]);
            end
            COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN: begin
                exp_q.push_back(op);
                exp_q.push_back(dat[15:8]);
                exp_q.push_back(dat[7:0]);
            end
            default: model_err = 1'b1;
        endcase
    endtask

    // Receiver emulation: acks each byte in its (stall+2)th valid cycle; withholds at ack number hold_at.
    task automatic run_cmd(input logic [7:0] op, input logic [15:0] blk, input logic [31:0] dat,
                           input logic [23:0] ds, input logic [23:0] id,
                           input int stall, input int hold_at, input bit stop_at_hold);
        bit fresh;
        bit first;
        int wait_left;
        logic [7:0] cur;
        got_q.delete();
        done_cnt = 0; err_cnt = 0; to_cnt = 0; stall_cyc = 0; acked = 0;
        ready_bad = 0; stable_bad = 0; lat_ov = 0; finished = 0;
        cur = 8'h00; wait_left = 0;
        for (int w = 0; w < 50 && req_ready !== 1'b1; w++) @(negedge clk);
        chk("req_ready_before_accept", req_ready, 1);
        req_cmd = op; req_block = blk; req_data = dat;
        req_delay_size = ds; req_init_delay = id; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd = 8'($urandom); req_block = 16'($urandom); req_data = $urandom;
        req_delay_size = 24'($urandom); req_init_delay = 24'($urandom);
        fresh = 1; first = 1;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (next) begin
                next = 1'b0;
                acked++;
                fresh = 1;
            end
            if (done) done_cnt++;
            if (cmd_error) err_cnt++;
            if (ack_timeout) to_cnt++;
            if (first) begin
                lat_ov = out_valid;
                first = 0;
            end
            if (out_valid) begin
                if (busy !== 1'b1 || req_ready !== 1'b0) ready_bad = 1;
                if (fresh) begin
                    got_q.push_back(out_byte);
                    cur = out_byte;
                    fresh = 0;
                    wait_left = stall + 2;
                end else if (out_byte !== cur) begin
                    stable_bad = 1;
                end
                if (acked == hold_at) begin
                    stall_cyc++;
                    if (stop_at_hold) finished = 1;
                end else begin
                    if (wait_left > 0) wait_left--;
                    if (wait_left == 0) next = 1'b1;
                end
            end else if (done_cnt + err_cnt + to_cnt > 0) begin
                finished = 1;
            end
            if (!finished) @(negedge clk);
        end
        chk("cmd_completes_in_bound", finished, 1);
    endtask

    task automatic check_result(input string name, input bit exp_err);
        chk({name, ".nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s.byte%0d", name, i), got_q[i], exp_q[i]);
        chk({name, ".done_pulses"}, done_cnt, exp_err ? 0 : 1);
        chk({name, ".cmd_error_pulses"}, err_cnt, exp_err ? 1 : 0);
        chk({name, ".opcode_at_T+1"}, lat_ov, exp_err ? 0 : 1);
        chk({name, ".ready_low_while_busy"}, ready_bad, 0);
        chk({name, ".byte_stable"}, stable_bad, 0);
        chk({name, ".req_ready_after"}, req_ready, 1);
        model_bs += exp_q.size();
        chk({name, ".bytes_sent"}, bytes_sent, model_bs & 16'hFFFF);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] blk;
        logic [31:0] dat;
        logic [23:0] ds;
        logic [23:0] id;
        int          nb;
        logic [55:0] bytes;
        bit          err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{COMMAND_WRITE_BLOCK_INSTR, 16'h002A, 32'hDEADBEEF, 24'h0, 24'h0, 6,
                    {COMMAND_WRITE_BLOCK_INSTR, 8'h2A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00}, 1'b0};
        vecs[1] = '{COMMAND_ALLOC_DELAY, 16'h0000, 32'h0, 24'h012345, 24'h000100, 7,
                    {COMMAND_ALLOC_DELAY, 8'h01, 8'h23, 8'h45, 8'h00, 8'h01, 8'h00}, 1'b0};
        vecs[2] = '{COMMAND_COMMIT_REG_UPDATES, 16'h0000, 32'h0, 24'h0, 24'h0, 1,
                    {COMMAND_COMMIT_REG_UPDATES, 48'h0}, 1'b0};
        vecs[3] = '{COMMAND_SET_INPUT_GAIN, 16'h0000, 32'hABCD7FFF, 24'h0, 24'h0, 3,
                    {COMMAND_SET_INPUT_GAIN, 8'h7F, 8'hFF, 32'h0}, 1'b0};
        vecs[4] = '{8'hEE, 16'h0000, 32'h0, 24'h0, 24'h0, 0, 56'h0, 1'b1};
        vecs[5] = '{COMMAND_UPDATE_BLOCK_REG_1, 16'h01C5, 32'h12349876, 24'h0, 24'h0, 4,
                    {COMMAND_UPDATE_BLOCK_REG_1, 8'hC5, 8'h98, 8'h76, 24'h0}, 1'b0};
        vecs[6] = '{COMMAND_END_PROGRAM, 16'h0000, 32'h0, 24'h0, 24'h0, 1,
                    {COMMAND_END_PROGRAM, 48'h0}, 1'b0};

        reset_n = 1'b0; req_valid = 1'b0; next = 1'b0;
        req_cmd = '0; req_block = '0; req_data = '0; req_delay_size = '0; req_init_delay = '0;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_byte", out_byte, 0);
        chk("rst.req_ready", req_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.cmd_error", cmd_error, 0);
        chk("rst.ack_timeout", ack_timeout, 0);
        chk("rst.bytes_sent", bytes_sent, 0);
        reset_n = 1'b1;
        @(negedge clk);

        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        chk("idle_next.bytes_sent", bytes_sent, 0);
        chk("idle_next.out_valid", out_valid, 0);

        for (int k = 0; k < 7; k++) begin
            v = vecs[k];
            exp_q.delete();
            for (int i = 0; i < v.nb; i++) exp_q.push_back(v.bytes[55-8*i -: 8]);
            run_cmd(v.cmd, v.blk, v.dat, v.ds, v.id, 0, -1, 1'b0);
            check_result($sformatf("vec%0d", k), v.err);
        end

        ref_model(COMMAND_WRITE_BLOCK_REG_0, 16'h0033, 32'h0000BEEF, 24'h0, 24'h0);
        run_cmd(COMMAND_WRITE_BLOCK_REG_0, 16'h0033, 32'h0000BEEF, 24'h0, 24'h0, 0, 3, 1'b0);
        chk("timeout.stalled_cycles", stall_cyc, ACK_TO);
        chk("timeout.pulse", to_cnt, 1);
        chk("timeout.no_done", done_cnt, 0);
        chk("timeout.bytes_presented", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk($sformatf("timeout.byte%0d", i), got_q[i], exp_q[i]);
        chk("timeout.out_valid", out_valid, 0);
        chk("timeout.req_ready", req_ready, 1);
        model_bs += 3;
        chk("timeout.bytes_sent", bytes_sent, model_bs & 16'hFFFF);

        run_cmd(COMMAND_WRITE_BLOCK_INSTR, 16'h0011, 32'h01020304, 24'h0, 24'h0, 1, 2, 1'b1);
        chk("midrst.valid_before", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst.out_valid_async", out_valid, 0);
        chk("midrst.out_byte", out_byte, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.bytes_sent", bytes_sent, 0);
        model_bs = 0;
        @(negedge clk);
        chk("midrst.no_done", done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        ref_model(COMMAND_SET_OUTPUT_GAIN, 16'h0, 32'h00004321, 24'h0, 24'h0);
        run_cmd(COMMAND_SET_OUTPUT_GAIN, 16'h0, 32'h00004321, 24'h0, 24'h0, 0, -1, 1'b0);
        check_result("after_rst", model_err);

        for (int k = 0; k < 40; k++) begin
            logic [7:0]  op;
            logic [15:0] blk;
            logic [31:0] dat;
            logic [23:0] ds;
            logic [23:0] id;
            int          r;
            r = $urandom_range(0, 12);
            op = (r < 11) ? ops[r] : 8'($urandom);
            blk = 16'($urandom); dat = $urandom;
            ds = 24'($urandom); id = 24'($urandom);
            ref_model(op, blk, dat, ds, id);
            run_cmd(op, blk, dat, ds, id, $urandom_range(0, 3), -1, 1'b0);
            check_result($sformatf("rnd%0d_op%02h", k, op), model_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
